dmem_resp: RTL and testbench

DMEM_RESP -- requirements
Module: dmem_resp

---
 rtl/mips_defs.sv | 14 +
 rtl/dmem_hostarb.sv | 57 +++++
 rtl/dmem_resp.sv | 76 +++++++
 tb/tb_dmem_resp.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_defs.sv
// mips_defs: shared address map and host FSM encoding for the data memory slice
package mips_defs;
  localparam logic [15:0] MMIO_PAGE = 16'hFFFF;
  localparam logic [31:0] ADDR_CNT  = 32'hFFFF_0000;
  localparam logic [31:0] ADDR_OUT  = 32'hFFFF_0004;
  localparam logic [31:0] ADDR_STAT = 32'hFFFF_0008;
  typedef enum logic [1:0] {H_IDLE, H_ACCESS, H_RESP} hstate_e;
  function automatic logic is_mmio(input logic [31:0] a);
    return a[31:16] == MMIO_PAGE;
  endfunction
  function automatic logic is_reg(input logic [31:0] a, input logic [31:0] r);
    return {a[31:2], 2'b00} == r;
  endfunction
endpackage

// File: rtl/dmem_hostarb.sv
// dmem_hostarb: host request FSM that defers to core stores and returns a one-cycle ack
module dmem_hostarb
  import mips_defs::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        hreq_i,
  input  logic        hwe_i,
  input  logic [31:0] haddr_i,
  input  logic [31:0] hwdata_i,
  input  logic        stall_i,
  input  logic [31:0] rdata_i,
  output logic        hack_o,
  output logic [31:0] hrdata_o,
  output logic        busy_o,
  output logic [31:0] addr_o,
  output logic [31:0] wdata_o,
  output logic        we_o
);
  hstate_e     state_q, state_d;
  logic        hwe_q, hwe_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic        start, done;
  assign start    = state_q == H_IDLE && hreq_i;
  assign done     = state_q == H_ACCESS && !stall_i;
  assign hack_o   = state_q == H_RESP;
  assign hrdata_o = hack_o ? rdata_q : '0;
  assign busy_o   = state_q != H_IDLE;
  assign addr_o   = addr_q;
  assign wdata_o  = wdata_q;
  assign we_o     = done && hwe_q && !reset;
  // Next state and request/response capture
  always_comb begin
    state_d = state_q == H_IDLE ? (hreq_i ? H_ACCESS : H_IDLE) :
              state_q == H_ACCESS ? (stall_i ? H_ACCESS : H_RESP) : H_IDLE;
    hwe_d   = start ? hwe_i : hwe_q;
    addr_d  = start ? haddr_i : addr_q;
    wdata_d = start ? hwdata_i : wdata_q;
    rdata_d = done ? (hwe_q ? '0 : rdata_i) : rdata_q;
  end
  // State and capture registers; reset drops any transaction in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= H_IDLE;
      hwe_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      hwe_q   <= hwe_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end
endmodule

// File: rtl/dmem_resp.sv
// dmem_resp: data memory with MMIO counter/outport/status and a deferrable host port
module dmem_resp
  import mips_defs::*;
#(
  parameter int          DEPTH   = 256,
  parameter logic [31:0] CNT_RST = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwriteM,
  input  logic [31:0] aluoutM,
  input  logic [31:0] writedataM,
  output logic [31:0] readdataM,
  input  logic        hreq,
  input  logic        hwe,
  input  logic [31:0] haddr,
  input  logic [31:0] hwdata,
  output logic        hack,
  output logic [31:0] hrdata,
  output logic [31:0] outport
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   cnt_q, cnt_d, out_q, out_d, h_rdata, h_addr, h_wdata;
  logic          h_we, h_busy, unused_ok;
  logic [AW-1:0] c_idx, h_idx;
  assign c_idx     = aluoutM[AW+1:2];
  assign h_idx     = h_addr[AW+1:2];
  assign cnt_d     = cnt_q + 32'd1;
  assign out_d     = (memwriteM && is_reg(aluoutM, ADDR_OUT)) ? writedataM :
                     (h_we && is_reg(h_addr, ADDR_OUT)) ? h_wdata : out_q;
  assign outport   = out_q;
  assign unused_ok = ^{aluoutM[1:0], h_addr[1:0]};
  dmem_hostarb u_hostarb (
    .clk      (clk),
    .reset    (reset),
    .hreq_i   (hreq),
    .hwe_i    (hwe),
    .haddr_i  (haddr),
    .hwdata_i (hwdata),
    .stall_i  (memwriteM),
    .rdata_i  (h_rdata),
    .hack_o   (hack),
    .hrdata_o (hrdata),
    .busy_o   (h_busy),
    .addr_o   (h_addr),
    .wdata_o  (h_wdata),
    .we_o     (h_we)
  );
  // RAM write port: host writes only land on edges where the core is not storing
  always_ff @(posedge clk) begin
    if (!reset && memwriteM && !is_mmio(aluoutM)) mem_q[c_idx] <= writedataM;
    else if (h_we && !is_mmio(h_addr)) mem_q[h_idx] <= h_wdata;
  end
  // Free-running cycle counter and output port register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= CNT_RST;
      out_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end
  // Combinational read decode for the core and host ports
  always_comb begin
    readdataM = !is_mmio(aluoutM) ? mem_q[c_idx] :
                is_reg(aluoutM, ADDR_CNT) ? cnt_q :
                is_reg(aluoutM, ADDR_OUT) ? out_q :
                is_reg(aluoutM, ADDR_STAT) ? {31'b0, h_busy} : '0;
    h_rdata   = !is_mmio(h_addr) ? mem_q[h_idx] :
                is_reg(h_addr, ADDR_CNT) ? cnt_q :
                is_reg(h_addr, ADDR_OUT) ? out_q :
                is_reg(h_addr, ADDR_STAT) ? {31'b0, h_busy} : '0;
  end
endmodule

// File: tb/tb_dmem_resp.sv
// tb_dmem_resp: randomized self-checking bench for dmem_resp against a memory-map model
module tb_dmem_resp;
  import mips_defs::*;
  localparam logic [31:0] CNT2 = 32'hFFFF_FFFA;
  logic        clk = 0, reset = 1, memwriteM = 0, hreq = 0, hwe = 0;
  logic [31:0] aluoutM = 0, writedataM = 0, haddr = 0, hwdata = 0;
  logic [31:0] readdataM, hrdata, outport, readdata2, hrdata2, outport2;
  logic        hack, hack2;
  int          total = 0, bad = 0, cyc = 0, rst_cyc = 0;
  logic [31:0] ram_m [256];
  bit          wr_m [256];
  logic [31:0] out_m = 0;

  always #5 clk = ~clk;

  dmem_resp dut (
    .clk(clk), .reset(reset), .memwriteM(memwriteM), .aluoutM(aluoutM),
    .writedataM(writedataM), .readdataM(readdataM), .hreq(hreq), .hwe(hwe),
    .haddr(haddr), .hwdata(hwdata), .hack(hack), .hrdata(hrdata), .outport(outport)
  );

  dmem_resp #(.CNT_RST(CNT2)) dut2 (
    .clk(clk), .reset(reset), .memwriteM(1'b0), .aluoutM(ADDR_CNT),
    .writedataM(32'h0), .readdataM(readdata2), .hreq(1'b0), .hwe(1'b0),
    .haddr(32'h0), .hwdata(32'h0), .hack(hack2), .hrdata(hrdata2), .outport(outport2)
  );

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % 32'd256);
  endfunction

  function automatic logic [31:0] ram_addr(input int idx);
    logic [15:0] up;
    up = 16'($urandom_range(0, 32'hFFFE));
    return {up, 6'($urandom), 8'(idx), 2'($urandom)};
  endfunction

  function automatic logic [31:0] cnt_m(input logic [31:0] base);
    return base + 32'(cyc - rst_cyc);
  endfunction

  task automatic tick();
    @(posedge clk);
    cyc++;
    if (reset) rst_cyc = cyc;
    #1;
  endtask

  task automatic do_reset();
    reset = 1;
    tick();
    tick();
    out_m = 0;
    reset = 0;
  endtask

  task automatic core_store(input logic [31:0] a, input logic [31:0] d);
    aluoutM = a;
    writedataM = d;
    memwriteM = 1;
    if (!reset && a[31:16] != 16'hFFFF) begin
      ram_m[widx(a)] = d;
      wr_m[widx(a)] = 1;
    end
    if (!reset && {a[31:2], 2'b00} == ADDR_OUT) out_m = d;
    tick();
    memwriteM = 0;
  endtask

  task automatic model_host(input bit we, input logic [31:0] a, input logic [31:0] d, output logic [31:0] exp);
    exp = 0;
    if (a[31:16] == 16'hFFFF) begin
      if (!we) exp = (a == ADDR_OUT) ? out_m : (a == ADDR_STAT) ? 32'd1 : 32'd0;
      else if (a == ADDR_OUT) out_m = d;
    end else if (we) begin
      ram_m[widx(a)] = d;
      wr_m[widx(a)] = 1;
    end else exp = ram_m[widx(a)];
  endtask

  task automatic host_txn(input bit we, input logic [31:0] a, input logic [31:0] d, input int stall,
                          input logic [31:0] ca, input bit tail, output logic [31:0] rd, output int lat);
    bit got;
    got = 0;
    rd = 0;
    lat = 0;
    hreq = 1;
    hwe = we;
    haddr = a;
    hwdata = d;
    for (int n = 1; n <= 40 && !got; n++) begin
      memwriteM = (n >= 2 && n <= stall + 1);
      aluoutM = ca;
      writedataM = $urandom;
      if (memwriteM) begin
        ram_m[widx(ca)] = writedataM;
        wr_m[widx(ca)] = 1;
      end
      tick();
      if (hack) begin
        got = 1;
        rd = hrdata;
        lat = n;
      end else begin
        total++;
        if (hrdata !== 32'h0) begin bad++; $display("FAIL hrdata_idle got=%h exp=0", hrdata); end
      end
    end
    memwriteM = 0;
    hreq = 0;
    total++;
    if (!got) begin bad++; $display("FAIL host_timeout addr=%h got=no_hack exp=hack", a); end
    if (tail) tick();
  endtask

  task automatic test_reset();
    reset = 1;
    aluoutM = ADDR_CNT;
    tick();
    tick();
    total++;
    if (hack !== 1'b0) begin bad++; $display("FAIL rst_hack got=%b exp=0", hack); end
    total++;
    if (hrdata !== 32'h0) begin bad++; $display("FAIL rst_hrdata got=%h exp=0", hrdata); end
    total++;
    if (outport !== 32'h0) begin bad++; $display("FAIL rst_outport got=%h exp=0", outport); end
    total++;
    if (readdataM !== 32'h0) begin bad++; $display("FAIL rst_cnt got=%h exp=0", readdataM); end
    total++;
    if (readdata2 !== CNT2) begin bad++; $display("FAIL rst_cnt2 got=%h exp=%h", readdata2, CNT2); end
    reset = 0;
  endtask

  task automatic test_core_rw();
    logic [31:0] a;
    core_store(32'h40, 32'hDEADBEEF);
    aluoutM = 32'h40;
    #1;
    total++;
    if (readdataM !== 32'hDEADBEEF) begin bad++; $display("FAIL core_rd40 got=%h exp=deadbeef", readdataM); end
    aluoutM = 32'h43;
    #1;
    total++;
    if (readdataM !== 32'hDEADBEEF) begin bad++; $display("FAIL core_rd43 got=%h exp=deadbeef", readdataM); end
    repeat (24) begin
      int idx;
      idx = $urandom_range(0, 255);
      if (idx == 16) idx = 17;
      core_store(ram_addr(idx), $urandom);
    end
    for (int j = 0; j < 256; j++) begin
      if (wr_m[j]) begin
        a = ram_addr(j);
        aluoutM = a;
        #1;
        total++;
        if (readdataM !== ram_m[j]) begin bad++; $display("FAIL core_alias a=%h got=%h exp=%h", a, readdataM, ram_m[j]); end
      end
    end
  endtask

  task automatic test_counter();
    do_reset();
    repeat (6) tick();
    aluoutM = ADDR_CNT;
    #1;
    total++;
    if (readdataM !== 32'd6) begin bad++; $display("FAIL cnt6 got=%h exp=6", readdataM); end
    total++;
    if (readdata2 !== 32'd0) begin bad++; $display("FAIL cnt2_wrap got=%h exp=0", readdata2); end
    repeat (4) tick();
    total++;
    if (readdataM !== 32'd10) begin bad++; $display("FAIL cnt10 got=%h exp=10", readdataM); end
    total++;
    if (readdata2 !== cnt_m(CNT2)) begin bad++; $display("FAIL cnt2_10 got=%h exp=%h", readdata2, cnt_m(CNT2)); end
  endtask

  task automatic test_outport();
    core_store(ADDR_OUT, 32'h5);
    total++;
    if (outport !== 32'h5) begin bad++; $display("FAIL outport got=%h exp=5", outport); end
    aluoutM = ADDR_OUT;
    #1;
    total++;
    if (readdataM !== 32'h5) begin bad++; $display("FAIL outport_rd got=%h exp=5", readdataM); end
    core_store(ADDR_CNT, 32'h1234_5678);
    aluoutM = ADDR_CNT;
    #1;
    total++;
    if (readdataM !== cnt_m(0)) begin bad++; $display("FAIL cnt_ro got=%h exp=%h", readdataM, cnt_m(0)); end
    core_store(32'hFFFF_0010, 32'hFFFF_FFFF);
    aluoutM = 32'hFFFF_0010;
    #1;
    total++;
    if (readdataM !== 32'h0) begin bad++; $display("FAIL unmapped got=%h exp=0", readdataM); end
    total++;
    if (outport !== out_m) begin bad++; $display("FAIL outport_keep got=%h exp=%h", outport, out_m); end
  endtask

  task automatic test_host_read();
    hreq = 1;
    hwe = 0;
    haddr = 32'h40;
    aluoutM = ADDR_STAT;
    #1;
    total++;
    if (readdataM !== 32'h0) begin bad++; $display("FAIL stat_idle got=%h exp=0", readdataM); end
    tick();
    total++;
    if (hack !== 1'b0 || readdataM !== 32'h1) begin bad++; $display("FAIL access got=%b/%h exp=0/1", hack, readdataM); end
    tick();
    total++;
    if (hack !== 1'b1 || hrdata !== 32'hDEADBEEF) begin bad++; $display("FAIL host_rd40 got=%b/%h exp=1/deadbeef", hack, hrdata); end
    total++;
    if (readdataM !== 32'h1) begin bad++; $display("FAIL stat_resp got=%h exp=1", readdataM); end
    hreq = 0;
    tick();
    total++;
    if (hack !== 1'b0 || hrdata !== 32'h0 || readdataM !== 32'h0) begin bad++; $display("FAIL after_resp got=%b/%h/%h exp=0/0/0", hack, hrdata, readdataM); end
  endtask

  task automatic test_host_random();
    logic [31:0] rd, exp;
    int lat, stall, idx;
    bit we;
    repeat (12) begin
      we = 1'($urandom);
      idx = $urandom_range(0, 63);
      if (idx == 16) idx = 18;
      if (!wr_m[idx]) we = 1;
      stall = $urandom_range(0, 3);
      host_txn(we, {22'h0, 8'(idx), 2'b00}, $urandom, stall, {22'h0, 8'($urandom_range(64, 127)), 2'b00}, 1, rd, lat);
      model_host(we, {22'h0, 8'(idx), 2'b00}, hwdata, exp);
      total++;
      if (rd !== exp || lat != stall + 2) begin bad++; $display("FAIL host_rand idx=%0d got=%h/%0d exp=%h/%0d", idx, rd, lat, exp, stall + 2); end
      aluoutM = {22'h0, 8'(idx), 2'b00};
      #1;
      total++;
      if (readdataM !== ram_m[idx]) begin bad++; $display("FAIL host_rand_ram idx=%0d got=%h exp=%h", idx, readdataM, ram_m[idx]); end
    end
  endtask

  task automatic test_deferred();
    logic [31:0] rd, exp;
    int lat;
    host_txn(1, 32'h80, 32'hCAFE_0080, 3, 32'h80, 1, rd, lat);
    model_host(1, 32'h80, 32'hCAFE_0080, exp);
    total++;
    if (lat != 5 || rd !== 32'h0) begin bad++; $display("FAIL defer_wr got=%0d/%h exp=5/0", lat, rd); end
    aluoutM = 32'h80;
    #1;
    total++;
    if (readdataM !== 32'hCAFE_0080) begin bad++; $display("FAIL defer_ram got=%h exp=cafe0080", readdataM); end
    host_txn(0, 32'h84, 32'h0, 2, 32'h84, 1, rd, lat);
    model_host(0, 32'h84, 32'h0, exp);
    total++;
    if (lat != 4 || rd !== exp) begin bad++; $display("FAIL defer_rd got=%0d/%h exp=4/%h", lat, rd, exp); end
  endtask

  task automatic test_host_mmio();
    logic [31:0] rd, exp;
    int lat;
    host_txn(1, ADDR_OUT, 32'h77, 0, 32'h100, 1, rd, lat);
    model_host(1, ADDR_OUT, 32'h77, exp);
    total++;
    if (outport !== 32'h77) begin bad++; $display("FAIL host_out got=%h exp=77", outport); end
    host_txn(0, ADDR_STAT, 32'h0, 1, 32'h100, 1, rd, lat);
    model_host(0, ADDR_STAT, 32'h0, exp);
    total++;
    if (rd !== exp) begin bad++; $display("FAIL host_stat got=%h exp=%h", rd, exp); end
    host_txn(0, ADDR_OUT, 32'h0, 0, 32'h100, 1, rd, lat);
    model_host(0, ADDR_OUT, 32'h0, exp);
    total++;
    if (rd !== exp) begin bad++; $display("FAIL host_outrd got=%h exp=%h", rd, exp); end
    host_txn(1, ADDR_CNT, 32'h0, 0, 32'h100, 1, rd, lat);
    aluoutM = ADDR_CNT;
    #1;
    total++;
    if (readdataM !== cnt_m(0)) begin bad++; $display("FAIL host_cnt_ro got=%h exp=%h", readdataM, cnt_m(0)); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    int lat;
    host_txn(0, 32'h40, 32'h0, 0, 32'h100, 0, rd, lat);
    total++;
    if (lat != 2 || rd !== 32'hDEADBEEF) begin bad++; $display("FAIL b2b_first got=%0d/%h exp=2/deadbeef", lat, rd); end
    host_txn(0, 32'h80, 32'h0, 0, 32'h100, 1, rd, lat);
    total++;
    if (lat != 3 || rd !== ram_m[32]) begin bad++; $display("FAIL b2b_second got=%0d/%h exp=3/%h", lat, rd, ram_m[32]); end
  endtask

  task automatic test_reset_access();
    core_store(32'h44, 32'h4444_4444);
    core_store(ADDR_OUT, 32'h9);
    hreq = 1;
    hwe = 1;
    haddr = 32'h40;
    hwdata = 32'h1234_5678;
    tick();
    reset = 1;
    hreq = 0;
    core_store(32'h44, 32'hBAD0_BAD0);
    tick();
    out_m = 0;
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (hack !== 1'b0) begin bad++; $display("FAIL rst_drop cyc=%0d got=%b exp=0", i, hack); end
      tick();
    end
    total++;
    if (outport !== 32'h0) begin bad++; $display("FAIL rst_out got=%h exp=0", outport); end
    aluoutM = 32'h40;
    #1;
    total++;
    if (readdataM !== 32'hDEADBEEF) begin bad++; $display("FAIL rst_ram40 got=%h exp=deadbeef", readdataM); end
    aluoutM = 32'h44;
    #1;
    total++;
    if (readdataM !== 32'h4444_4444) begin bad++; $display("FAIL rst_store got=%h exp=44444444", readdataM); end
    aluoutM = ADDR_CNT;
    #1;
    total++;
    if (readdataM !== cnt_m(0)) begin bad++; $display("FAIL rst_cnt_again got=%h exp=%h", readdataM, cnt_m(0)); end
  endtask

  initial begin
    test_reset();
    test_core_rw();
    test_counter();
    test_outport();
    test_host_read();
    test_host_random();
    test_deferred();
    test_host_mmio();
    test_back_to_back();
    test_reset_access();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
